lfu_replacement_unit: RTL and testbench

//  Parametrised LFU replacement-state unit for an N-way set-associative cache.

---
 rtl/lfu_replacement_unit_if.sv | 29 ++
 rtl/lfu_replacement_unit.sv | 132 +++++++++++++
 tb/tb_lfu_replacement_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lfu_replacement_unit_if.sv
// LFU replacement unit bus: update masks, read request and read results.
// Master drives requests; slave (the unit) returns counters and victim.
interface lfu_replacement_unit_if #(
  parameter int ADDR_W = 10,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 4
);
  localparam int VW = $clog2(WAYS);

  logic                  enable;
  logic [ADDR_W-1:0]     address;
  logic [WAYS-1:0]       line_sum;
  logic [WAYS-1:0]       line_reset;
  logic                  count_read;
  logic [WAYS*CNT_W-1:0] count_out;
  logic [VW-1:0]         victim_way;
  logic                  read_valid;
  logic                  busy;

  modport master (
    output enable, address, line_sum, line_reset, count_read,
    input  count_out, victim_way, read_valid, busy
  );

  modport slave (
    input  enable, address, line_sum, line_reset, count_read,
    output count_out, victim_way, read_valid, busy
  );
endinterface

// File: rtl/lfu_replacement_unit.sv
// LFU replacement state: per-set, per-way saturating use counters.
// Optional LFU_AGING_EN: saturating hit halves the whole set first.
module lfu_replacement_unit #(
  parameter int ADDR_W = 10,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   gen_reset,
  lfu_replacement_unit_if.slave  bus
);
  localparam int VW   = $clog2(WAYS);
  localparam int SETS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] MAXC = '1;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     sweep_q, sweep_d;
  logic [WAYS*CNT_W-1:0] mem_q [SETS];
  logic [WAYS*CNT_W-1:0] count_q;
  logic [VW-1:0]         victim_q;
  logic                  valid_q;

  logic                  busy;
  logic                  upd_en;
  logic                  rd_en;
  logic [WAYS*CNT_W-1:0] row_old;
  logic [WAYS*CNT_W-1:0] row_d;
  logic [WAYS-1:0]       hit;
  logic [CNT_W-1:0]      cnt_v [WAYS];
  logic [CNT_W-1:0]      minc;
  logic [VW-1:0]         vic_d;

  assign row_old = mem_q[bus.address];
  assign hit     = bus.line_sum & ~bus.line_reset;

  // FSM state and sweep pointer; reset restarts the clear sweep
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state: sweep every set once, then go idle
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = S_IDLE;
      end
      S_IDLE: sweep_d = '0;
      default: state_d = S_INIT;
    endcase
  end

  // FSM outputs: busy gates every update and read
  always_comb begin
    busy   = (state_q == S_INIT);
    upd_en = !busy && bus.enable;
    rd_en  = !busy && bus.count_read;
  end

  // New row: clears first, then optional aging, then increments
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      cnt_v[i] = row_old[i*CNT_W +: CNT_W];
      if (bus.line_reset[i]) cnt_v[i] = '0;
    end
`ifdef LFU_AGING_EN
    begin
      logic sat;
      sat = 1'b0;
      for (int i = 0; i < WAYS; i++)
        if (hit[i] && cnt_v[i] == MAXC) sat = 1'b1;
      if (sat)
        for (int i = 0; i < WAYS; i++) cnt_v[i] = cnt_v[i] >> 1;
    end
`endif
    row_d = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit[i] && cnt_v[i] != MAXC) cnt_v[i] = cnt_v[i] + 1'b1;
      row_d[i*CNT_W +: CNT_W] = cnt_v[i];
    end
  end

  // Victim: lowest count, ties resolved to the lowest way index
  always_comb begin
    vic_d = '0;
    minc  = row_old[CNT_W-1:0];
    for (int i = 1; i < WAYS; i++) begin
      if (row_old[i*CNT_W +: CNT_W] < minc) begin
        minc  = row_old[i*CNT_W +: CNT_W];
        vic_d = VW'(i);
      end
    end
  end

  // Counter storage: sweep clear while busy, masked update when idle
  always_ff @(posedge clk) begin
    if (busy)
      mem_q[sweep_q] <= '0;
    else if (upd_en)
      mem_q[bus.address] <= row_d;
  end

  // Read pipeline: captures the pre-update row and its victim
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      count_q  <= '0;
      victim_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= rd_en;
      if (rd_en) begin
        count_q  <= row_old;
        victim_q <= vic_d;
      end
    end
  end

  assign bus.count_out  = count_q;
  assign bus.victim_way = victim_q;
  assign bus.read_valid = valid_q;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_lfu_replacement_unit.sv
// Directed bench for lfu_replacement_unit (ADDR_W=10, WAYS=4, CNT_W=4).
// Vector table plus hand sequences for sweep, aging and reset restart.
module tb_lfu_replacement_unit;
  logic clk = 1'b0;
  logic gen_reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lfu_replacement_unit_if #(.ADDR_W(10), .WAYS(4), .CNT_W(4)) bus ();

  lfu_replacement_unit #(.ADDR_W(10), .WAYS(4), .CNT_W(4)) dut (
    .clk       (clk),
    .gen_reset (gen_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [9:0]  addr;
    logic [3:0]  sum;
    logic [3:0]  rst;
    logic        rd;
    logic        ev;
    logic        chk;
    logic [15:0] ec;
    logic [1:0]  evic;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [9:0] a,
                       input logic [3:0] s, input logic [3:0] r,
                       input logic rd);
    bus.enable     = en;
    bus.address    = a;
    bus.line_sum   = s;
    bus.line_reset = r;
    bus.count_read = rd;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic upd(input logic [9:0] a, input logic [3:0] s,
                     input logic [3:0] r);
    drive(1'b1, a, s, r, 1'b0);
    tick();
    idle_in();
  endtask

  task automatic rd_chk(input string nm, input logic [9:0] a,
                        input logic [15:0] ec, input logic [1:0] ev);
    drive(1'b0, a, '0, '0, 1'b1);
    tick();
    idle_in();
    check({nm, ".valid"}, 16'(bus.read_valid), 16'h1);
    check({nm, ".cnt"}, bus.count_out, ec);
    check({nm, ".vic"}, 16'(bus.victim_way), 16'(ev));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_reset();
    #1 gen_reset = 1'b1;
    tick();
    gen_reset = 1'b0;
  endtask

  initial begin
    int n;
    int m;
    logic [15:0] exp_age;
    idle_in();

    // reset state
    tick();
    tick();
    check("rst.busy", 16'(bus.busy), 16'h1);
    check("rst.valid", 16'(bus.read_valid), 16'h0);
    check("rst.cnt", bus.count_out, 16'h0);
    check("rst.vic", 16'(bus.victim_way), 16'h0);
    gen_reset = 1'b0;
    wait_idle(n);
    check("sweep.cycles", 16'(n), 16'd1024);

    // table vectors
    vq.push_back('{0, 10'd0,    4'h0, 4'h0, 1, 1, 1, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd10,   4'h0, 4'h0, 1, 1, 1, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd1023, 4'h0, 4'h0, 1, 1, 1, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd10,   4'h1, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd10,   4'h1, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd10,   4'h1, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd10,   4'h2, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd10,   4'h0, 4'h0, 1, 1, 1, 16'h0013, 2'd2});
    vq.push_back('{1, 10'd10,   4'h1, 4'h1, 1, 1, 1, 16'h0013, 2'd2});
    vq.push_back('{0, 10'd10,   4'h0, 4'h0, 1, 1, 1, 16'h0010, 2'd0});
    vq.push_back('{0, 10'd10,   4'h0, 4'h0, 0, 0, 1, 16'h0010, 2'd0});
    vq.push_back('{0, 10'd10,   4'hF, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd10,   4'h0, 4'h0, 1, 1, 1, 16'h0010, 2'd0});
    vq.push_back('{1, 10'd20,   4'hF, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd20,   4'hF, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd30,   4'hF, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd30,   4'h9, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd30,   4'h9, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{1, 10'd30,   4'h8, 4'h0, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd20,   4'h0, 4'h0, 1, 1, 1, 16'h2222, 2'd0});
    vq.push_back('{0, 10'd30,   4'h0, 4'h0, 1, 1, 1, 16'h4113, 2'd1});
    vq.push_back('{1, 10'd30,   4'h0, 4'hA, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd30,   4'h0, 4'h0, 1, 1, 1, 16'h0103, 2'd1});
    vq.push_back('{1, 10'd30,   4'h3, 4'h2, 0, 0, 0, 16'h0000, 2'd0});
    vq.push_back('{0, 10'd30,   4'h0, 4'h0, 1, 1, 1, 16'h0104, 2'd1});

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].addr, vq[i].sum, vq[i].rst, vq[i].rd);
      tick();
      check($sformatf("v%0d.valid", i), 16'(bus.read_valid), 16'(vq[i].ev));
      if (vq[i].chk) begin
        check($sformatf("v%0d.cnt", i), bus.count_out, vq[i].ec);
        check($sformatf("v%0d.vic", i), 16'(bus.victim_way), 16'(vq[i].evic));
      end
    end
    idle_in();

    // saturation / aging on set 5: build 15,6,3,0
    for (int k = 0; k < 3; k++) upd(10'd5, 4'h7, 4'h0);
    for (int k = 0; k < 3; k++) upd(10'd5, 4'h3, 4'h0);
    for (int k = 0; k < 9; k++) upd(10'd5, 4'h1, 4'h0);
    rd_chk("sat.pre", 10'd5, 16'h036F, 2'd3);
`ifdef LFU_AGING_EN
    exp_age = 16'h0138;
`else
    exp_age = 16'h036F;
`endif
    drive(1'b1, 10'd5, 4'h1, 4'h0, 1'b1);
    tick();
    idle_in();
    check("sat.rdold", bus.count_out, 16'h036F);
    rd_chk("sat.post", 10'd5, exp_age, 2'd3);

    // reset after updates, then again mid-sweep
    pulse_reset();
    repeat (100) tick();
    check("mid.busy", 16'(bus.busy), 16'h1);
    pulse_reset();
    m = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 10'd5, 4'hF, 4'h0, 1'b1);
      tick();
      m++;
      check($sformatf("busy.rv%0d", k), 16'(bus.read_valid), 16'h0);
    end
    idle_in();
    wait_idle(n);
    check("resweep.cycles", 16'(n + m), 16'd1024);
    rd_chk("post.a5", 10'd5, 16'h0000, 2'd0);
    rd_chk("post.a10", 10'd10, 16'h0000, 2'd0);
    rd_chk("post.a30", 10'd30, 16'h0000, 2'd0);
    rd_chk("post.a0", 10'd0, 16'h0000, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
